// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared scoreboard widths, defaults and BCD helpers
//
// Purpose : constants shared by the score counter and the display decoder.
// Ports   : none (package).
package scoreboard_pkg;

  localparam int unsigned DIGIT_W           = 4;
  localparam int unsigned SCORE_W           = 7;
  localparam int unsigned MAX_SCORE_DEFAULT = 99;

  typedef logic [DIGIT_W-1:0] bcd_t;
  typedef logic [SCORE_W-1:0] score_t;

  function automatic bcd_t bcd_tens(input int unsigned v);
    return bcd_t'(v / 10);
  endfunction

  function automatic bcd_t bcd_ones(input int unsigned v);
    return bcd_t'(v % 10);
  endfunction

endpackage

// File: rtl/bcd_digit_updown.sv
// rtl/bcd_digit_updown.sv - single BCD digit with increment/decrement
//
// Purpose : one decimal digit that counts up/down and wraps 9<->0,
//           reporting carry/borrow for the next digit.
// Ports   : clk_i     clock
//           rst_i     synchronous active-high clear to RESET_VAL
//           inc_i     increment this cycle
//           dec_i     decrement this cycle (ignored if inc_i is set)
//           digit_o   current digit value
//           carry_o   inc_i while digit is 9 (digit wraps to 0)
//           borrow_o  dec_i while digit is 0 (digit wraps to 9)
module bcd_digit_updown
  import scoreboard_pkg::*;
#(
  parameter bcd_t RESET_VAL = '0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output bcd_t digit_o,
  output logic carry_o,
  output logic borrow_o
);

  bcd_t digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (inc_i) begin
      digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    end else if (dec_i) begin
      digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) digit_q <= RESET_VAL;
    else       digit_q <= digit_d;
  end

  assign digit_o  = digit_q;
  assign carry_o  = inc_i & (digit_q == 4'd9);
  assign borrow_o = dec_i & ~inc_i & (digit_q == 4'd0);

endmodule

// File: rtl/score_counter.sv
// rtl/score_counter.sv - saturating two-digit BCD score counter
//
// Purpose : counts rising edges of count_up_i/count_down_i into a score
//           held as two BCD digits plus a parallel binary register.
// Ports   : clk_1khz      scoreboard clock
//           rst_i         synchronous active-high reset
//           count_up_i    increment request (rising edge counts)
//           count_down_i  decrement request (rising edge counts)
//           ones_o        BCD ones digit
//           tens_o        BCD tens digit
//           score_o       binary score
//           at_max_o      score equals MAX_SCORE
//           changed_o     one-cycle strobe after a score change
module score_counter
  import scoreboard_pkg::*;
#(
  parameter int unsigned MAX_SCORE = MAX_SCORE_DEFAULT,
  parameter int unsigned MIN_SCORE = 0
) (
  input  logic               clk_1khz,
  input  logic               rst_i,
  input  logic               count_up_i,
  input  logic               count_down_i,
  output logic [DIGIT_W-1:0] ones_o,
  output logic [DIGIT_W-1:0] tens_o,
  output logic [SCORE_W-1:0] score_o,
  output logic               at_max_o,
  output logic               changed_o
);

  localparam score_t MAX_S = score_t'(MAX_SCORE);
  localparam score_t MIN_S = score_t'(MIN_SCORE);

  logic   up_q, dn_q;
  logic   up_ev, dn_ev;
  logic   do_inc, do_dec;
  logic   ones_carry, ones_borrow;
  logic   tens_carry_unused, tens_borrow_unused;
  score_t score_q, score_d;
  logic   at_max_q, at_max_d;
  logic   changed_q, changed_d;

  assign up_ev = count_up_i & ~up_q;
  assign dn_ev = count_down_i & ~dn_q;

  // Simultaneous edges cancel; saturation is judged on the binary copy.
  assign do_inc = up_ev & ~dn_ev & (score_q < MAX_S);
  assign do_dec = dn_ev & ~up_ev & (score_q > MIN_S);

  always_comb begin
    score_d = score_q;
    if (do_inc)      score_d = score_q + 7'd1;
    else if (do_dec) score_d = score_q - 7'd1;
    at_max_d  = (score_d == MAX_S);
    changed_d = do_inc | do_dec;
  end

  // The history registers track the inputs even during reset, so a request
  // already high when reset releases must fall and rise again to count.
  always_ff @(posedge clk_1khz) begin
    up_q <= count_up_i;
    dn_q <= count_down_i;
    if (rst_i) begin
      score_q   <= MIN_S;
      at_max_q  <= (MIN_S == MAX_S);
      changed_q <= 1'b0;
    end else begin
      score_q   <= score_d;
      at_max_q  <= at_max_d;
      changed_q <= changed_d;
    end
  end

  bcd_digit_updown #(.RESET_VAL(bcd_ones(MIN_SCORE))) u_ones (
    .clk_i    (clk_1khz),
    .rst_i    (rst_i),
    .inc_i    (do_inc),
    .dec_i    (do_dec),
    .digit_o  (ones_o),
    .carry_o  (ones_carry),
    .borrow_o (ones_borrow)
  );

  // Score never exceeds 99, so the tens digit's own carry/borrow stay unused.
  bcd_digit_updown #(.RESET_VAL(bcd_tens(MIN_SCORE))) u_tens (
    .clk_i    (clk_1khz),
    .rst_i    (rst_i),
    .inc_i    (ones_carry),
    .dec_i    (ones_borrow),
    .digit_o  (tens_o),
    .carry_o  (tens_carry_unused),
    .borrow_o (tens_borrow_unused)
  );

  assign score_o   = score_q;
  assign at_max_o  = at_max_q;
  assign changed_o = changed_q;

endmodule
